// File: rtl/player_pkg.sv
// player_pkg: shared types and button indices for the player motion logic
package player_pkg;
  typedef logic [31:0] pos_t;
  typedef enum logic [1:0] {GROUNDED, RISE, HANG, FALL} jump_state_t;
  localparam int BTN_JUMP  = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;
endpackage

// File: rtl/player_motion_ctrl_btn_sync.sv
// btn_sync: 2-flop button synchronizer with a per-frame sample register and rising-edge output
module btn_sync #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tick,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic [W-1:0] rise
);
  logic [W-1:0] s1, s2, prev;
  // synchronizer always runs; the previous sample only advances on a frame tick
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1   <= '0;
      s2   <= '0;
      prev <= '0;
    end else begin
      s1 <= d;
      s2 <= s1;
      if (tick) prev <= s2;
    end
  assign q    = s2;
  assign rise = s2 & ~prev;
endmodule

// File: rtl/player_motion_ctrl.sv
// player_motion_ctrl: per-frame player position with horizontal clamp (or wrap under PLAYER_HWRAP_EN) and jump FSM
module player_motion_ctrl
  import player_pkg::*;
#(
  parameter pos_t H_MIN       = 0,
  parameter pos_t H_MAX       = 600,
  parameter pos_t H_START     = 300,
  parameter pos_t H_STEP      = 4,
  parameter pos_t GROUND_V    = 400,
  parameter pos_t JUMP_HEIGHT = 120,
  parameter pos_t V_STEP      = 8,
  parameter pos_t HANG_FRAMES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        pause,
  input  logic [3:0]  btns,
  output logic [31:0] player_hOffset,
  output logic [31:0] player_vOffset,
  output logic        on_ground,
  output logic        jump_active
);
  localparam pos_t APEX      = GROUND_V - JUMP_HEIGHT;
  localparam pos_t HANG_LAST = (HANG_FRAMES == 0) ? 0 : HANG_FRAMES - 1;
  jump_state_t state, state_n;
  pos_t h, h_n, v, v_n, cnt, cnt_n, h_lo, h_hi;
  logic [3:0] b, rise;
  logic active, left_only, right_only, unused_rise;
  assign active = frame_tick & ~pause;
  btn_sync #(.W(4)) u_sync (
    .clk (clk),
    .rst (rst),
    .tick(active),
    .d   (btns),
    .q   (b),
    .rise(rise)
  );
  assign unused_rise = ^rise[3:1];
  assign left_only  = b[BTN_LEFT] & ~b[BTN_RIGHT];
  assign right_only = b[BTN_RIGHT] & ~b[BTN_LEFT];
`ifdef PLAYER_HWRAP_EN
  assign h_lo = H_MAX;
  assign h_hi = H_MIN;
`else
  assign h_lo = H_MIN;
  assign h_hi = H_MAX;
`endif
  assign h_n = left_only  ? ((h < H_MIN + H_STEP) ? h_lo : h - H_STEP) :
               right_only ? ((h + H_STEP > H_MAX) ? h_hi : h + H_STEP) : h;
  // state and positions advance only on an active frame tick
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= GROUNDED;
      h     <= H_START;
      v     <= GROUND_V;
      cnt   <= '0;
    end else if (active) begin
      state <= state_n;
      h     <= h_n;
      v     <= v_n;
      cnt   <= cnt_n;
    end
  // jump sequencing; bounds are tested before any subtraction so nothing underflows
  always_comb begin
    state_n = state;
    v_n     = v;
    cnt_n   = cnt;
    case (state)
      GROUNDED: state_n = rise[BTN_JUMP] ? RISE : GROUNDED;
      RISE:
        if (b[BTN_DOWN]) state_n = FALL;
        else if (v <= APEX + V_STEP) begin
          v_n     = APEX;
          cnt_n   = '0;
          state_n = HANG;
        end else v_n = v - V_STEP;
      HANG:
        if (b[BTN_DOWN] || cnt == HANG_LAST) state_n = FALL;
        else cnt_n = cnt + 1;
      FALL:
        if (v + V_STEP >= GROUND_V) begin
          v_n     = GROUND_V;
          state_n = GROUNDED;
        end else v_n = v + V_STEP;
    endcase
  end
  // status flags decoded from the registered state
  always_comb begin
    on_ground   = state == GROUNDED;
    jump_active = state != GROUNDED;
  end
  assign player_hOffset = h;
  assign player_vOffset = v;
endmodule

// File: tb/tb_player_motion_ctrl.sv
// tb_player_motion_ctrl: table vectors plus jump/reset sequences checked through an expected-value queue
module tb_player_motion_ctrl;
  typedef struct packed {
    logic [31:0] h;
    logic [31:0] v;
    logic        og;
    logic        ja;
  } exp_t;
  typedef struct {
    logic [3:0] b;
    logic       p;
    exp_t       e;
  } vec_t;
  logic clk = 0, rst = 1, frame_tick = 0, pause = 0;
  logic [3:0] btns = 0;
  logic [31:0] player_hOffset, player_vOffset;
  logic on_ground, jump_active;
  int compared = 0, mismatched = 0;
  exp_t q[$];
  vec_t tbl[8];
  player_motion_ctrl dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .pause(pause), .btns(btns),
    .player_hOffset(player_hOffset), .player_vOffset(player_vOffset),
    .on_ground(on_ground), .jump_active(jump_active)
  );
  always #5 clk = ~clk;
  task automatic check(input string n, input exp_t e);
    compared++;
    if ({player_hOffset, player_vOffset, on_ground, jump_active} !== e) begin
      mismatched++;
      $display("FAIL %s: got h=%0d v=%0d og=%0b ja=%0b, want h=%0d v=%0d og=%0b ja=%0b",
               n, player_hOffset, player_vOffset, on_ground, jump_active, e.h, e.v, e.og, e.ja);
    end
  endtask
  task automatic do_tick(input string n, input exp_t e);
    exp_t x;
    @(negedge clk);
    frame_tick = 1;
    q.push_back(e);
    @(posedge clk);
    #1 frame_tick = 0;
    x = q.pop_front();
    check(n, x);
  endtask
  task automatic set_btns(input logic [3:0] v);
    @(negedge clk);
    btns = v;
    repeat (3) @(posedge clk);
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    btns = 0;
    pause = 0;
    repeat (2) @(negedge clk);
    rst = 0;
    #1 check("reset", '{300, 400, 1, 0});
  endtask
  task automatic run_jump(input logic hold);
    set_btns(4'b0001);
    do_tick("jump_edge", '{300, 400, 0, 1});
    if (!hold) set_btns(4'b0000);
    for (int k = 1; k <= 15; k++) do_tick("rise", '{300, 400 - 8 * k, 0, 1});
    for (int k = 1; k <= 4; k++) do_tick("hang", '{300, 280, 0, 1});
    for (int k = 1; k <= 15; k++) do_tick("fall", '{300, 280 + 8 * k, k == 15, k != 15});
    if (hold) for (int k = 0; k < 5; k++) do_tick("held_no_rejump", '{300, 400, 1, 0});
  endtask
  initial begin
    tbl[0] = '{4'b0000, 0, '{300, 400, 1, 0}};
    tbl[1] = '{4'b1000, 0, '{304, 400, 1, 0}};
    tbl[2] = '{4'b1000, 0, '{308, 400, 1, 0}};
    tbl[3] = '{4'b0100, 0, '{304, 400, 1, 0}};
    tbl[4] = '{4'b1100, 0, '{304, 400, 1, 0}};
    tbl[5] = '{4'b1000, 1, '{304, 400, 1, 0}};
    tbl[6] = '{4'b0000, 0, '{304, 400, 1, 0}};
    tbl[7] = '{4'b0100, 0, '{300, 400, 1, 0}};
    do_reset();
    for (int i = 0; i < 10; i++) do_tick("idle", '{300, 400, 1, 0});
    foreach (tbl[i]) begin
      set_btns(tbl[i].b);
      pause = tbl[i].p;
      do_tick($sformatf("table%0d", i), tbl[i].e);
      pause = 0;
    end
    do_reset();
    set_btns(4'b1000);
    for (int k = 1; k <= 80; k++) begin
`ifdef PLAYER_HWRAP_EN
      do_tick("right_wrap", '{(k <= 75) ? 300 + 4 * k : 4 * (k - 76), 400, 1, 0});
`else
      do_tick("right_clamp", '{(k <= 75) ? 300 + 4 * k : 600, 400, 1, 0});
`endif
    end
    do_reset();
    run_jump(0);
    do_reset();
    run_jump(1);
    do_reset();
    set_btns(4'b0001);
    do_tick("ff_edge", '{300, 400, 0, 1});
    set_btns(4'b0000);
    for (int k = 1; k <= 5; k++) do_tick("ff_rise", '{300, 400 - 8 * k, 0, 1});
    set_btns(4'b0010);
    do_tick("ff_down", '{300, 360, 0, 1});
    for (int k = 1; k <= 5; k++) do_tick("ff_fall", '{300, 360 + 8 * k, k == 5, k != 5});
    set_btns(4'b0001);
    do_tick("ar_edge", '{300, 400, 0, 1});
    set_btns(4'b1000);
    for (int k = 1; k <= 3; k++) do_tick("ar_rise", '{300 + 4 * k, 400 - 8 * k, 0, 1});
    @(negedge clk);
    #2 rst = 1;
    #1 check("async_reset", '{300, 400, 1, 0});
    @(negedge clk);
    btns = 4'b1001;
    rst = 0;
    pause = 1;
    repeat (3) @(posedge clk);
    for (int k = 0; k < 5; k++) do_tick("paused", '{300, 400, 1, 0});
    pause = 0;
    btns = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/player_motion_ctrl.md
Name: player_motion_ctrl

Overview:
- Upstream stage of the video controller; generates the `player_hOffset` / `player_vOffset` pair that the display compare stage consumes.
- Samples the four player buttons once per video frame and applies horizontal steps with clamping.
- Runs a jump state machine (rise, hang, fall) on the vertical axis.
- Runs in the system clock domain and is advanced by a one-cycle frame strobe derived from VS.

Parameters:
- H_MIN, 0: leftmost legal hOffset.
- H_MAX, 600: rightmost legal hOffset.
- H_START, 300: hOffset after reset.
- H_STEP, 4: horizontal pixels moved per frame.
- GROUND_V, 400: vOffset when standing; must be >= JUMP_HEIGHT.
- JUMP_HEIGHT, 120: apex distance above ground.
- V_STEP, 8: vertical pixels moved per frame while rising or falling.
- HANG_FRAMES, 4: frames held at apex.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: asynchronous, active-high reset.
- frame_tick, input, 1: one-clk pulse per frame (VS start).
- pause, input, 1: when high, frame_tick is ignored.
- btns, input, 4: raw buttons; [0] jump, [1] down, [2] left, [3] right.
- player_hOffset, output, 32: horizontal position, unsigned.
- player_vOffset, output, 32: vertical position, unsigned.
- on_ground, output, 1: high in GROUNDED.
- jump_active, output, 1: high in RISE, HANG or FALL.

Behaviour:
- Reset is asynchronous and active-high.
  - Outputs: hOffset=H_START, vOffset=GROUND_V, state=GROUNDED, on_ground=1, jump_active=0.
  - Internal: hang counter=0, synchronizer flops=0, previous jump sample=0.
  - Reset mid-jump returns the block to ground immediately.
- btns pass through a 2-flop synchronizer.
  - Synchronized value is sampled only on an active tick: frame_tick=1 and pause=0.
- All position and state updates happen on the clk edge at which an active tick is seen. Outputs are registered, so they are visible 1 cycle after the tick.
- Horizontal movement, per active tick:
  - Left only: hOffset -= H_STEP, floored at H_MIN.
  - Right only: hOffset += H_STEP, capped at H_MAX.
  - Both or neither: no change.
  - Horizontal movement is independent of jump state.
- Jump edge detection: jump_edge = (jump sample this tick) AND NOT (previous tick's sample). The previous sample updates on active ticks only.
- Vertical state machine (APEX = GROUND_V - JUMP_HEIGHT):
  - GROUNDED:
    - jump_edge -> RISE; vOffset unchanged this tick.
    - A held button does not retrigger a jump.
  - RISE:
    - If down is sampled -> FALL (fast-fall); vOffset unchanged.
    - Else if vOffset - V_STEP <= APEX: vOffset=APEX, hang counter=0, -> HANG.
    - Else vOffset -= V_STEP.
  - HANG:
    - If down is sampled, or the counter equals HANG_FRAMES-1 -> FALL.
    - Else the counter increments.
    - HANG_FRAMES=0 behaves as 1.
  - FALL:
    - If vOffset + V_STEP >= GROUND_V: vOffset=GROUND_V, -> GROUNDED.
    - Else vOffset += V_STEP.
  - jump_edge outside GROUNDED is ignored (no double jump).
- Arithmetic: 32-bit unsigned. Comparisons are done before subtracting so values never underflow. Clamping is checked before the value is written.
- frame_tick held high for several cycles: each cycle counts as a tick. The upstream source guarantees a single-cycle pulse.
- pause high: all state is frozen. Synchronizer flops keep running.

Optional Feature:
- Macro: PLAYER_HWRAP_EN.
- Defined: horizontal movement wraps instead of clamping.
  - A right step that would exceed H_MAX loads H_MIN.
  - A left step that would go below H_MIN loads H_MAX.
- Undefined: clamping as described in Behaviour.
- Vertical behaviour is identical in both builds.

Decomposition:
- Package player_pkg:
  - typedef enum {GROUNDED, RISE, HANG, FALL} jump_state_t
  - button index constants BTN_JUMP=0, BTN_DOWN=1, BTN_LEFT=2, BTN_RIGHT=3
  - shared 32-bit position typedef
- Sub-module btn_sync: 4-bit 2-flop synchronizer plus a per-frame sample register with rising-edge output. It is reusable by the scroll logic.

Test Plan:
- Reset release, no buttons, 10 ticks -> hOffset=300, vOffset=400, on_ground=1 throughout.
- Hold right for 80 ticks:
  - hOffset reaches 600 at tick 75 and stays at 600.
  - With PLAYER_HWRAP_EN, tick 76 gives hOffset=0.
- Press jump for 1 tick, release:
  - vOffset decreases by 8 per tick and reaches 280 on rise tick 15.
  - Holds 280 for 4 ticks.
  - Falls 8 per tick back to 400, then on_ground=1.
  - jump_active is high for the whole rise/hang/fall sequence.
- Hold jump continuously through the landing -> no second jump; state stays GROUNDED.
- Jump, then assert down at vOffset=360 -> next tick state=FALL; vOffset returns to 400 after 5 ticks.
- Assert rst asynchronously mid-RISE with no clk edge -> outputs immediately 300/400, on_ground=1; pause=1 with ticks -> no output change.
